// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK levels and bit-counter width.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StMemAddr,
    StMemAck,
    StWrite,
    StWriteAck,
    StRead,
    StRdAck,
    StWait
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Counts 0..8 bits within a byte.
  localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop synchronizers, optional glitch filter, edge and START/STOP detect.
// Optional majority filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_cond (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Idle bus is high on both lines, so reset the pipelines high to avoid false edges.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // A single-sample pulse never wins the 3-sample vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sda_level = sda_s;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a byte register bank: address match, pointer byte, burst write, sequential read.
// Define I2C_SLAVE_GLITCH_FILTER_EN to enable the SCL/SDA glitch filter in i2c_line_cond.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  input  logic [AW-1:0] loc_raddr,
  output logic [7:0]    loc_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          addr_hit
);

  logic sda_level, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_cond u_line_cond (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 hit_q, hit_d;
  logic                 strobe_q, strobe_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 reg_we;
  logic [7:0]           rx_byte, rd_byte;
  logic                 last_bit;
  logic [7:0]           regs_q [DEPTH];

  assign rx_byte  = {shift_q[6:0], sda_level};
  assign rd_byte  = regs_q[ptr_q];
  assign last_bit = (bit_cnt_q == BIT_CNT_W'(7));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    hit_d     = 1'b0;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg_we    = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWait: begin
        end

        StAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                hit_d   = 1'b1;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
                state_d = StAddrAck;
              end else begin
                busy_d  = 1'b0;
                state_d = StIdle;
              end
            end
          end
        end

        StMemAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              bit_cnt_d = '0;
              ptr_d     = rx_byte[AW-1:0];
              state_d   = StMemAck;
            end
          end
        end

        StWrite: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              bit_cnt_d = '0;
              reg_we    = 1'b1;
              strobe_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = ptr_q + AW'(1);
              state_d   = StWriteAck;
            end
          end
        end

        // First fall after the byte starts the ACK low, the next fall ends it.
        StAddrAck, StMemAck, StWriteAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == StAddrAck && rw_q) begin
                sda_oe_d  = ~rd_byte[7];
                shift_d   = {rd_byte[6:0], 1'b0};
                bit_cnt_d = BIT_CNT_W'(1);
                state_d   = StRead;
              end else if (state_q == StAddrAck) begin
                state_d = StMemAddr;
              end else begin
                state_d = StWrite;
              end
            end
          end
        end

        StRead: begin
          if (scl_fall) begin
            if (bit_cnt_q == BIT_CNT_W'(8)) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + AW'(1);
              bit_cnt_d = '0;
              state_d   = StRdAck;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            if (sda_level == ACK) begin
              shift_d   = rd_byte;
              bit_cnt_d = '0;
              state_d   = StRead;
            end else begin
              state_d = StWait;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  // Open-drain: only ever pull low; reset releases the line without waiting for a clock.
  assign sda       = (sda_oe_q && !rst) ? 1'b0 : 1'bz;
  assign loc_rdata = regs_q[loc_raddr];
  assign wr_strobe = strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign addr_hit  = hit_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register-bank model and per-cycle monitor.
module tb_i2c_slave_regs;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int          Q     = 8;  // clk cycles per quarter SCL period

  logic          clk = 1'b0;
  logic          rst;
  logic          scl;
  logic          m_sda;
  logic [AW-1:0] loc_raddr;
  logic [7:0]    loc_rdata;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          addr_hit;
  wire           sda_bus;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_slave_regs #(
    .SLAVE_ADDR (7'h50),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda_bus),
    .loc_raddr (loc_raddr),
    .loc_rdata (loc_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .addr_hit  (addr_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0]  mem_model [DEPTH];
  int unsigned m_ptr = 0;
  int unsigned exp_a [$];
  logic [7:0]  exp_d [$];
  logic        quiet = 1'b0;
  int          hit_cnt = 0;
  int          strobe_cnt = 0;
  logic [7:0]  last_wa, last_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: strobes against the expected queue; idle-time register and busy view.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (addr_hit) hit_cnt++;
      if (wr_strobe) begin
        strobe_cnt++;
        last_wa = 8'(wr_addr);
        last_wd = wr_data;
        if (exp_a.size() == 0) begin
          check("unexpected wr_strobe", 32'(wr_strobe), 32'd0);
        end else begin
          check("wr_addr", 32'(wr_addr), exp_a.pop_front());
          check("wr_data", 32'(wr_data), 32'(exp_d.pop_front()));
        end
      end
      if (quiet) begin
        check("loc_rdata idle", 32'(loc_rdata), 32'(mem_model[loc_raddr]));
        check("busy idle", 32'(busy), 32'd0);
      end
    end
  end

  task automatic bit_xfer(input logic b, input logic glitch, output logic rb);
    wclk(Q);
    m_sda = b;
    wclk(Q);
    scl = 1'b1;
    wclk(Q / 2);
    if (glitch) begin
      scl = 1'b0;
      wclk(1);
      scl = 1'b1;
    end
    wclk(Q / 2);
    rb = sda_bus;
    wclk(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    quiet = 1'b0;
    if (scl == 1'b0) begin
      wclk(Q);
      m_sda = 1'b1;
      wclk(Q);
      scl = 1'b1;
      wclk(Q);
    end
    m_sda = 1'b0;
    wclk(Q);
    scl = 1'b0;
  endtask

  // Driving 0 then releasing under SCL high doubles as a final read ACK.
  task automatic i2c_stop();
    wclk(Q);
    m_sda = 1'b0;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    m_sda = 1'b1;
    wclk(2 * Q);
    quiet = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], (i == gbit), rb);
    bit_xfer(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, rb);
      d[i] = rb;
    end
  endtask

  task automatic bus_write(input logic [7:0] ma, input int n, input logic [7:0] d0,
                           input logic [7:0] d1);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA0, -1, ack);
    check("write addr ack", 32'(ack), 32'd0);
    check("busy after hit", 32'(busy), 32'd1);
    send_byte(ma, -1, ack);
    check("mem addr ack", 32'(ack), 32'd0);
    m_ptr = ma % DEPTH;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      exp_a.push_back(m_ptr);
      exp_d.push_back(d);
      mem_model[m_ptr] = d;
      m_ptr = (m_ptr + 1) % DEPTH;
      send_byte(d, -1, ack);
      check("data ack", 32'(ack), 32'd0);
    end
    i2c_stop();
    check("strobes drained", exp_a.size(), 32'd0);
  endtask

  task automatic bus_read(input int n, output logic [7:0] r0, output logic [7:0] r1);
    logic       ack;
    logic [7:0] d;
    r0 = 8'h00;
    r1 = 8'h00;
    i2c_start();
    send_byte(8'hA1, -1, ack);
    check("read addr ack", 32'(ack), 32'd0);
    for (int k = 0; k < n; k++) begin
      recv_byte(d);
      check("read byte vs model", 32'(d), 32'(mem_model[m_ptr]));
      m_ptr = (m_ptr + 1) % DEPTH;
      if (k == 0) r0 = d;
      else r1 = d;
      if (k < n - 1) bit_xfer(1'b0, 1'b0, ack);
    end
    i2c_stop();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] r0, r1;
    int         h0, s0;

    for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
    rst       = 1'b1;
    scl       = 1'b1;
    m_sda     = 1'b1;
    loc_raddr = '0;
    wclk(5);
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset addr_hit", 32'(addr_hit), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_data", 32'(wr_data), 32'd0);
    check("reset sda released", 32'(sda_bus), 32'd1);
    check("reset loc_rdata", 32'(loc_rdata), 32'd0);
    rst = 1'b0;
    wclk(5);
    quiet = 1'b1;

    // Burst write to registers 3 and 4
    h0 = hit_cnt;
    s0 = strobe_cnt;
    bus_write(8'h03, 2, 8'h11, 8'h22);
    check("write addr_hit count", hit_cnt - h0, 32'd1);
    check("write strobe count", strobe_cnt - s0, 32'd2);
    check("last strobe addr", 32'(last_wa), 32'd4);
    check("last strobe data", 32'(last_wd), 32'h22);
    loc_raddr = 4'd3;
    wclk(1);
    check("loc reg3", 32'(loc_rdata), 32'h11);
    loc_raddr = 4'd4;
    wclk(1);
    check("loc reg4", 32'(loc_rdata), 32'h22);

    // Set pointer, then sequential read of two bytes
    s0 = strobe_cnt;
    bus_write(8'h03, 0, 8'h00, 8'h00);
    bus_read(2, r0, r1);
    check("read byte0", 32'(r0), 32'h11);
    check("read byte1", 32'(r1), 32'h22);
    check("read no strobe", strobe_cnt - s0, 32'd0);

    // Address mismatch: no ACK, no hit, not busy, following byte ignored
    h0 = hit_cnt;
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'hA2, -1, ack);
    check("mismatch nack", 32'(ack), 32'd1);
    check("mismatch busy", 32'(busy), 32'd0);
    send_byte(8'h55, -1, ack);
    check("mismatch data nack", 32'(ack), 32'd1);
    i2c_stop();
    check("mismatch addr_hit", hit_cnt - h0, 32'd0);
    check("mismatch strobe", strobe_cnt - s0, 32'd0);

    // Pointer wrap 15 -> 0, then read from the wrapped pointer (1)
    bus_write(8'h01, 1, 8'h5A, 8'h00);
    bus_write(8'h0F, 2, 8'hAA, 8'hBB);
    check("wrap last strobe addr", 32'(last_wa), 32'd0);
    loc_raddr = 4'd15;
    wclk(1);
    check("loc reg15", 32'(loc_rdata), 32'hAA);
    loc_raddr = 4'd0;
    wclk(1);
    check("loc reg0", 32'(loc_rdata), 32'hBB);
    bus_read(1, r0, r1);
    check("read after wrap", 32'(r0), 32'h5A);

    // 1-clk SCL glitch during the first address bit
    h0 = hit_cnt;
    i2c_start();
    send_byte(8'hA0, 7, ack);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    check("glitch filtered ack", 32'(ack), 32'd0);
    check("glitch filtered hit", hit_cnt - h0, 32'd1);
`else
    check("glitch corrupts ack", 32'(ack), 32'd1);
    check("glitch corrupts hit", hit_cnt - h0, 32'd0);
`endif
    i2c_stop();

    // Reset while the slave drives a 0 data bit (reg3 = 8'h11, MSB 0)
    bus_write(8'h03, 0, 8'h00, 8'h00);
    i2c_start();
    send_byte(8'hA1, -1, ack);
    check("pre-reset addr ack", 32'(ack), 32'd0);
    wclk(Q);
    check("slave drives data 0", 32'(sda_bus), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst sda released", 32'(sda_bus), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst addr_hit", 32'(addr_hit), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst wr_data", 32'(wr_data), 32'd0);
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
    m_ptr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      loc_raddr = AW'(i);
      #1;
      check("rst register cleared", 32'(loc_rdata), 32'd0);
    end
    wclk(2);
    scl = 1'b1;
    m_sda = 1'b1;
    wclk(5);
    rst = 1'b0;
    wclk(5);
    quiet = 1'b1;

    // Post-reset write/read sanity
    bus_write(8'h07, 1, 8'hC3, 8'h00);
    bus_write(8'h07, 0, 8'h00, 8'h00);
    bus_read(1, r0, r1);
    check("post-reset read", 32'(r0), 32'hC3);

    wclk(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
